// File: rtl/bit_serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial adder controller.
// master drives start/a/b/cin; slave returns busy/done/sum/cout.
interface bit_serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_add_ctrl.sv
// Serialises a+b+cin LSB-first through a one-bit full adder; done pulses WIDTH cycles after start.
// No backpressure: start is only sampled in IDLE, ignored while busy, never queued.
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  bit_serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c_nxt;
  logic [WIDTH-1:0] rs_nxt;
  logic             accept;
  logic             last;

  assign s      = ra[0] ^ rb[0] ^ c;
  assign c_nxt  = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign rs_nxt = {s, rs[WIDTH-1:1]};
  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == SHIFT) && (cnt == LAST);

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra  <= '0;
      rb  <= '0;
      rs  <= '0;
      c   <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      ra  <= bus.a;
      rb  <= bus.b;
      rs  <= '0;
      c   <= bus.cin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      ra  <= {1'b0, ra[WIDTH-1:1]};
      rb  <= {1'b0, rb[WIDTH-1:1]};
      rs  <= rs_nxt;
      c   <= c_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers only move on the completing edge so they hold through the next SHIFT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.done <= last;
      if (last) begin
        bus.sum  <= rs_nxt;
        bus.cout <= c_nxt;
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench: directed adds on an 8-bit instance plus back-to-back random adds on 8- and 5-bit instances.
module tb_bit_serial_add_ctrl;
  localparam int W0 = 8;
  localparam int W1 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serial_add_ctrl_if #(.WIDTH(W0)) bus0 ();
  bit_serial_add_ctrl_if #(.WIDTH(W1)) bus1 ();

  bit_serial_add_ctrl #(.WIDTH(W0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bit_serial_add_ctrl #(.WIDTH(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          act [2];
  int          acc [2];
  logic [32:0] res [2];
  logic [32:0] exp_res [2];
  int          wid [2] = '{W0, W1};
  logic [7:0]  last_sum = 8'h00;
  int          prev [2] = '{-1, -1};
  int          npulse [2] = '{0, 0};
  int          dn_rst = 0;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [32:0] dut_res(input int i);
    return (i == 0) ? 33'({bus0.cout, bus0.sum}) : 33'({bus1.cout, bus1.sum});
  endfunction

  function automatic logic dut_busy(input int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic dut_done(input int i);
    return (i == 0) ? bus0.done : bus1.done;
  endfunction

  // One clock edge: the model decides acceptance from the inputs in force at the edge,
  // then both instances are compared against the timeline implied by the accept edge.
  task automatic tick();
    logic        st [2];
    logic [32:0] ia [2];
    logic [32:0] ib [2];
    logic        ci [2];
    int          age;
    bit          want_busy;
    bit          want_done;
    st[0] = bus0.start; ia[0] = 33'(bus0.a); ib[0] = 33'(bus0.b); ci[0] = bus0.cin;
    st[1] = bus1.start; ia[1] = 33'(bus1.a); ib[1] = 33'(bus1.b); ci[1] = bus1.cin;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst && st[i] && (!act[i] || (cyc - acc[i] >= wid[i] + 2))) begin
        act[i] = 1'b1;
        acc[i] = cyc;
        res[i] = ia[i] + ib[i] + 33'(ci[i]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      age       = cyc - acc[i];
      want_busy = act[i] && (age <= wid[i]);
      want_done = act[i] && (age == wid[i]);
      if (want_done) exp_res[i] = res[i];
      chk($sformatf("busy%0d@%0d", i, cyc), 33'(dut_busy(i)), 33'(want_busy));
      chk($sformatf("done%0d@%0d", i, cyc), 33'(dut_done(i)), 33'(want_done));
      chk($sformatf("result%0d@%0d", i, cyc), dut_res(i), exp_res[i]);
    end
  endtask

  task automatic apply_reset(input string tag);
    #2 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      act[i]     = 1'b0;
      exp_res[i] = '0;
    end
    last_sum = 8'h00;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), 33'(dut_busy(i)), 33'd0);
      chk($sformatf("%s_done%0d", tag, i), 33'(dut_done(i)), 33'd0);
      chk($sformatf("%s_result%0d", tag, i), dut_res(i), 33'd0);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Directed add on the 8-bit instance; rp1/rp2 re-pulse start (with zero operands) at edge k+rp.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input int rp1, input int rp2);
    int dn;
    dn = 0;
    bus0.a = a; bus0.b = b; bus0.cin = ci; bus0.start = 1'b1;
    tick();
    for (int j = 1; j <= W0 + 1; j++) begin
      bus0.a     = 8'($urandom);
      bus0.b     = 8'($urandom);
      bus0.cin   = 1'($urandom);
      bus0.start = (j == rp1) || (j == rp2);
      if (bus0.start) begin
        bus0.a = 8'h00;
        bus0.b = 8'h00;
      end
      tick();
      if (bus0.done) dn++;
      if (j < W0) chk({tag, "_sum_hold"}, 33'(bus0.sum), 33'(last_sum));
      if (j == W0) begin
        chk({tag, "_sum"}, 33'(bus0.sum), 33'(es));
        chk({tag, "_cout"}, 33'(bus0.cout), 33'(ec));
      end
    end
    bus0.start = 1'b0;
    chk({tag, "_pulses"}, 33'(dn), 33'd1);
    chk({tag, "_idle"}, 33'(bus0.busy), 33'd0);
    last_sum = es;
  endtask

  initial begin
    bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    apply_reset("rst0");

    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 0);
    run_op("ff_01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0);
    run_op("ff_00c",  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, 0);
    run_op("ff_ffc",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 0);
    run_op("after_ff", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 0);
    run_op("ignore",  8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 3, 8);

    // Abort an operation between edges k+4 and k+5.
    bus0.a = 8'h77; bus0.b = 8'h11; bus0.cin = 1'b0; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (4) tick();
    apply_reset("rst_mid");
    for (int j = 0; j < W0 + 2; j++) begin
      tick();
      if (bus0.done) dn_rst++;
    end
    chk("rst_mid_no_done", 33'(dn_rst), 33'd0);
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 0);

    // Start held high with fresh random operands every cycle on both widths.
    for (int t = 0; t < 40; t++) begin
      bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.cin = 1'($urandom); bus0.start = 1'b1;
      bus1.a = 5'($urandom); bus1.b = 5'($urandom); bus1.cin = 1'($urandom); bus1.start = 1'b1;
      tick();
      if (bus0.done) begin
        if (prev[0] >= 0) chk("period8", 33'(cyc - prev[0]), 33'(W0 + 2));
        prev[0] = cyc;
        npulse[0]++;
      end
      if (bus1.done) begin
        if (prev[1] >= 0) chk("period5", 33'(cyc - prev[1]), 33'(W1 + 2));
        prev[1] = cyc;
        npulse[1]++;
      end
    end
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    chk("held_pulses8", 33'(npulse[0]), 33'd4);
    chk("held_pulses5", 33'(npulse[1]), 33'd5);
    repeat (W0 + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
